// File: rtl/genesis_bram_pkg.sv
// Shared definitions for the Genesis simple-dual-port block-RAM array.
// Lane width selection, controller states and bank sizing limits.
package genesis_bram_pkg;

    localparam int LANE_W_9       = 9;
    localparam int LANE_W_8       = 8;
    localparam int MAX_BANK_DEPTH = 2048;

    typedef enum logic [0:0] {
        READY = 1'b0,
        CLEAR = 1'b1
    } bram_state_e;

    // Widths divisible by 9 use 9-bit lanes (parity-capable); otherwise 8-bit lanes.
    function automatic int lane_width(input int data_width);
        return ((data_width % LANE_W_9) == 0) ? LANE_W_9 : LANE_W_8;
    endfunction

endpackage

// File: rtl/bram_sdp_bank.sv
// One behavioural simple-dual-port bank: lane-enabled writes, registered read,
// read-old-data on same-address collisions. Output register is resettable.
module bram_sdp_bank #(
    parameter int DATA_WIDTH = 36,
    parameter int BANK_DEPTH = 1024,
    parameter int ADDR_W     = 10,
    parameter int LANE_W     = 9,
    parameter int NUM_LANES  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [NUM_LANES-1:0]  wbe,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [BANK_DEPTH];

    // Lane-granular write into the storage array.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (wbe[k]) begin
                    mem_r[waddr][k*LANE_W +: LANE_W] <= wdata[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Registered read port; holds its value when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/bram_sdp_array.sv
// Banked simple-dual-port RAM with byte/lane enables, selectable read latency,
// wrapper-level write-first forwarding, address-range flagging and a clear sequencer.
module bram_sdp_array
    import genesis_bram_pkg::*;
#(
    parameter int DATA_WIDTH     = 36,
    parameter int DEPTH          = 2048,
    parameter int BANK_DEPTH     = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}},
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LANE_W    = lane_width(DATA_WIDTH),
    localparam int NUM_LANES = DATA_WIDTH / LANE_W
) (
    input  logic                  CLK_i,
    input  logic                  RESET_ni,
    input  logic                  CLEAR_i,
    output logic                  BUSY_o,
    input  logic                  WEN_i,
    input  logic [AW-1:0]         WADDR_i,
    input  logic [DATA_WIDTH-1:0] WDATA_i,
    input  logic [NUM_LANES-1:0]  WBE_i,
    input  logic                  REN_i,
    input  logic [AW-1:0]         RADDR_i,
    output logic [DATA_WIDTH-1:0] RDATA_o,
    output logic                  RVALID_o,
    output logic                  ADDR_ERR_o
);

    localparam int NUM_BANKS = (DEPTH + BANK_DEPTH - 1) / BANK_DEPTH;
    localparam int BAW       = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int LAW       = (AW < BAW) ? AW : BAW;
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    bram_state_e           state_r, state_nxt_s;
    logic [AW-1:0]         clr_cnt_r, clr_cnt_nxt_s;

    logic                  clearing_s, wr_oob_s, rd_oob_s, wr_go_s, rd_acc_s;
    logic [AW-1:0]         wr_addr_s, wr_bank_s, rd_bank_s;
    logic [LAW-1:0]        wr_loc_s, rd_loc_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [NUM_LANES-1:0]  wr_be_s, fwd_lane_s;
    logic [DATA_WIDTH-1:0] fwd_bits_s;
    logic [DATA_WIDTH-1:0] bank_rdata_s [NUM_BANKS];

    logic                  rvalid1_r, rerr1_r;
    logic [AW-1:0]         rbank1_r;
    logic [DATA_WIDTH-1:0] fwd_bits1_r, fwd_data1_r;
    logic [DATA_WIDTH-1:0] rd_word_s, rd_data1_s;

    // Controller state and clear address counter.
    always_ff @(posedge CLK_i or negedge RESET_ni) begin
        if (!RESET_ni) begin
            state_r   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt_r <= {AW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
        end
    end

    // Next-state: a clear request is only taken from READY; clear ends after DEPTH-1.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            READY: begin
                if (CLEAR_i) begin
                    state_nxt_s   = CLEAR;
                    clr_cnt_nxt_s = {AW{1'b0}};
                end else begin
                    state_nxt_s   = READY;
                end
            end
            CLEAR: begin
                if (clr_cnt_r == AW'(DEPTH - 1)) begin
                    state_nxt_s   = READY;
                    clr_cnt_nxt_s = {AW{1'b0}};
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + AW'(32'd1);
                end
            end
            default: begin
                state_nxt_s   = READY;
                clr_cnt_nxt_s = {AW{1'b0}};
            end
        endcase
    end

    assign BUSY_o = (state_r == CLEAR);

    // Port decode: the clear sequencer owns the write port while clearing.
    always_comb begin
        clearing_s = (state_r == CLEAR);
        wr_oob_s   = ({1'b0, WADDR_i} >= DEPTH_X);
        rd_oob_s   = ({1'b0, RADDR_i} >= DEPTH_X);
        if (clearing_s) begin
            wr_addr_s  = clr_cnt_r;
            wr_data_s  = INIT_VALUE;
            wr_be_s    = {NUM_LANES{1'b1}};
            wr_go_s    = 1'b1;
            rd_acc_s   = 1'b0;
            fwd_lane_s = {NUM_LANES{1'b0}};
        end else begin
            wr_addr_s  = WADDR_i;
            wr_data_s  = WDATA_i;
            wr_be_s    = WBE_i;
            wr_go_s    = WEN_i & ~wr_oob_s;
            rd_acc_s   = REN_i;
            fwd_lane_s = ((WRITE_FIRST != 0) && WEN_i && (WADDR_i == RADDR_i)) ?
                         WBE_i : {NUM_LANES{1'b0}};
        end
        wr_bank_s = wr_addr_s >> BAW;
        wr_loc_s  = wr_addr_s[LAW-1:0];
        rd_bank_s = RADDR_i >> BAW;
        rd_loc_s  = RADDR_i[LAW-1:0];
    end

    // Expand per-lane forward enables to a bit mask.
    always_comb begin
        fwd_bits_s = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < NUM_LANES; k++) begin
            fwd_bits_s[k*LANE_W +: LANE_W] = {LANE_W{fwd_lane_s[k]}};
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic bank_we_s, bank_re_s;
        assign bank_we_s = wr_go_s && (wr_bank_s == AW'(b));
        assign bank_re_s = rd_acc_s && !rd_oob_s && (rd_bank_s == AW'(b));

        bram_sdp_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .BANK_DEPTH (BANK_DEPTH),
            .ADDR_W     (LAW),
            .LANE_W     (LANE_W),
            .NUM_LANES  (NUM_LANES)
        ) u_bank (
            .clk   (CLK_i),
            .rst_n (RESET_ni),
            .we    (bank_we_s),
            .waddr (wr_loc_s),
            .wdata (wr_data_s),
            .wbe   (wr_be_s),
            .re    (bank_re_s),
            .raddr (rd_loc_s),
            .rdata (bank_rdata_s[b])
        );
    end

    // Read-side sideband delayed to line up with the bank output register.
    always_ff @(posedge CLK_i or negedge RESET_ni) begin
        if (!RESET_ni) begin
            rvalid1_r   <= 1'b0;
            rerr1_r     <= 1'b0;
            rbank1_r    <= {AW{1'b0}};
            fwd_bits1_r <= {DATA_WIDTH{1'b0}};
            fwd_data1_r <= {DATA_WIDTH{1'b0}};
        end else begin
            rvalid1_r <= rd_acc_s;
            if (rd_acc_s) begin
                rerr1_r     <= rd_oob_s;
                rbank1_r    <= rd_bank_s;
                fwd_bits1_r <= fwd_bits_s;
                fwd_data1_r <= WDATA_i;
            end
        end
    end

    // Bank select, write-first merge and out-of-range zeroing.
    always_comb begin
        rd_word_s = {DATA_WIDTH{1'b0}};
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_word_s = rd_word_s | ((rbank1_r == AW'(b)) ? bank_rdata_s[b] : {DATA_WIDTH{1'b0}});
        end
        rd_data1_s = rerr1_r ? {DATA_WIDTH{1'b0}} :
                     ((rd_word_s & ~fwd_bits1_r) | (fwd_data1_r & fwd_bits1_r));
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  rvalid2_r, rerr2_r;
        logic [DATA_WIDTH-1:0] rdata2_r;

        // Extra output stage; data only moves when a result arrives.
        always_ff @(posedge CLK_i or negedge RESET_ni) begin
            if (!RESET_ni) begin
                rvalid2_r <= 1'b0;
                rerr2_r   <= 1'b0;
                rdata2_r  <= {DATA_WIDTH{1'b0}};
            end else begin
                rvalid2_r <= rvalid1_r;
                rerr2_r   <= rvalid1_r & rerr1_r;
                if (rvalid1_r) begin
                    rdata2_r <= rd_data1_s;
                end
            end
        end

        assign RDATA_o    = rdata2_r;
        assign RVALID_o   = rvalid2_r;
        assign ADDR_ERR_o = rerr2_r;
    end else begin : g_lat1
        assign RDATA_o    = rd_data1_s;
        assign RVALID_o   = rvalid1_r;
        assign ADDR_ERR_o = rvalid1_r & rerr1_r;
    end

endmodule
